// File: rtl/cmac_pkg.sv
// Shared constants and state encoding for the CMAC TX arbiter.
package cmac_pkg;

    localparam int AXIS_DW = 512;
    localparam int AXIS_KW = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Width of a port index; a single port still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmac_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first asserted request at or after ptr, wrapping.
module rr_pick
    import cmac_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    int w_k;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        w_k = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = int'(ptr) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (req[w_k]) begin
                any = 1'b1;
                idx = W'(w_k);
            end
        end
    end

endmodule

// File: rtl/cmac_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the CMAC axis_tx port from NUM_PORTS requesters.
module cmac_tx_arbiter
    import cmac_pkg::*;
#(
    parameter int  NUM_PORTS      = 4,
    parameter bit  DROP_WHEN_DOWN = 1'b1,
    localparam int GW             = id_width(NUM_PORTS)
) (
    input  logic                           tx_clk,
    input  logic                           resetn,
    input  logic                           stat_rx_aligned,
    input  logic [NUM_PORTS*AXIS_DW-1:0]   s_tdata,
    input  logic [NUM_PORTS*AXIS_KW-1:0]   s_tkeep,
    input  logic [NUM_PORTS-1:0]           s_tlast,
    input  logic [NUM_PORTS-1:0]           s_tvalid,
    output logic [NUM_PORTS-1:0]           s_tready,
    output logic [AXIS_DW-1:0]             m_tdata,
    output logic [AXIS_KW-1:0]             m_tkeep,
    output logic                           m_tlast,
    output logic                           m_tuser,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           link_up,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy,
    output logic [31:0]                    pkt_count,
    output logic [31:0]                    drop_count
);

    logic [3:0]          r_sync;
    state_t              r_state;
    logic [GW-1:0]       r_rr_ptr;
    logic [GW-1:0]       r_grant_id;
    logic [31:0]         r_pkt_count;
    logic [31:0]         r_drop_count;

    logic                w_any;
    logic [GW-1:0]       w_idx;
    logic [GW-1:0]       w_next_ptr;
    logic [AXIS_DW-1:0]  w_sel_data;
    logic [AXIS_KW-1:0]  w_sel_keep;
    logic                w_sel_last;
    logic                w_sel_valid;
    logic                w_pass;

    // Four-flop alignment synchronizer; link is reported down out of reset.
    always_ff @(posedge tx_clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[2:0], stat_rx_aligned};
        end
    end

    rr_pick #(
        .N (NUM_PORTS),
        .W (GW)
    ) u_pick (
        .req (s_tvalid),
        .ptr (r_rr_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_sel_data  = s_tdata[int'(r_grant_id)*AXIS_DW +: AXIS_DW];
    assign w_sel_keep  = s_tkeep[int'(r_grant_id)*AXIS_KW +: AXIS_KW];
    assign w_sel_last  = s_tlast[r_grant_id];
    assign w_sel_valid = s_tvalid[r_grant_id];
    assign w_pass      = (r_state == ST_PASS);
    assign w_next_ptr  = (int'(r_grant_id) == NUM_PORTS - 1) ? '0 : r_grant_id + GW'(1);

    assign m_tdata    = w_pass ? w_sel_data : '0;
    assign m_tkeep    = w_pass ? w_sel_keep : '0;
    assign m_tlast    = w_pass & w_sel_last;
    assign m_tvalid   = w_pass & w_sel_valid;
    assign m_tuser    = 1'b0;
    assign link_up    = r_sync[3];
    assign grant_id   = r_grant_id;
    assign busy       = (r_state != ST_IDLE);
    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;

    // Only the granted requester ever sees ready; DROP sinks it unconditionally.
    always_comb begin
        s_tready = '0;
        if (r_state == ST_PASS) begin
            s_tready[r_grant_id] = m_tready;
        end else if (r_state == ST_DROP) begin
            s_tready[r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge tx_clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any && link_up) begin
                        r_grant_id <= w_idx;
                        r_state    <= ST_PASS;
                    end else if (w_any && DROP_WHEN_DOWN) begin
                        r_grant_id <= w_idx;
                        r_state    <= ST_DROP;
                    end
                end
                ST_PASS: begin
                    if (m_tvalid && m_tready && m_tlast) begin
                        r_pkt_count <= r_pkt_count + 32'd1;
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (w_sel_valid && w_sel_last) begin
                        r_drop_count <= r_drop_count + 32'd1;
                        r_rr_ptr     <= w_next_ptr;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
